// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions for the EX stage:
// ALU function codes, mux encodings and the ID/EX bundle layout.
package cpu_pipe_pkg;

  localparam int ID_EX_W = 230;

  localparam logic [5:0] ALU_ADD   = 6'b000000;
  localparam logic [5:0] ALU_SUB   = 6'b000001;
  localparam logic [5:0] ALU_AND   = 6'b011000;
  localparam logic [5:0] ALU_OR    = 6'b011110;
  localparam logic [5:0] ALU_XOR   = 6'b010110;
  localparam logic [5:0] ALU_NOR   = 6'b010001;
  localparam logic [5:0] ALU_PASSA = 6'b011010;
  localparam logic [5:0] ALU_SLL   = 6'b100000;
  localparam logic [5:0] ALU_SRL   = 6'b100001;
  localparam logic [5:0] ALU_SRA   = 6'b100011;
  localparam logic [5:0] ALU_EQ    = 6'b110011;
  localparam logic [5:0] ALU_NEQ   = 6'b110001;
  localparam logic [5:0] ALU_LT    = 6'b110101;
  localparam logic [5:0] ALU_LEZ   = 6'b111101;
  localparam logic [5:0] ALU_LTZ   = 6'b111011;
  localparam logic [5:0] ALU_GTZ   = 6'b111111;

  localparam logic [1:0] REGDST_RD = 2'b00;
  localparam logic [1:0] REGDST_RT = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;
  localparam logic [1:0] REGDST_K0 = 2'b11;

  localparam logic [4:0] REG_RA = 5'd31;
  localparam logic [4:0] REG_K0 = 5'd26;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC4 = 2'b10;

  localparam int RS_DATA_LSB  = 0;
  localparam int RT_DATA_LSB  = 32;
  localparam int RS_LSB       = 64;
  localparam int RT_LSB       = 69;
  localparam int RD_LSB       = 74;
  localparam int SIGN_BIT     = 79;
  localparam int ALU_FUN_LSB  = 80;
  localparam int ALU_SRC2_BIT = 86;
  localparam int ALU_SRC1_BIT = 87;
  localparam int BADDR_LSB    = 88;
  localparam int MEM_WR_BIT   = 120;
  localparam int MEM_RD_BIT   = 121;
  localparam int REG_WR_BIT   = 122;
  localparam int M2R_LSB      = 123;
  localparam int LU_DATA_LSB  = 125;
  localparam int LU_OP_BIT    = 157;
  localparam int PC4_LSB      = 158;
  localparam int SHAMT_LSB    = 190;
  localparam int IMM_LSB      = 195;
  localparam int BRANCH_BIT   = 227;
  localparam int REGDST_LSB   = 228;

  // MSB first, so a plain cast of the bundle lines up with the offsets.
  typedef struct packed {
    logic [1:0]  reg_dst;
    logic        branch;
    logic [31:0] imm32;
    logic [4:0]  shamt;
    logic [31:0] pc_plus4;
    logic        lu_op;
    logic [31:0] lu_data;
    logic [1:0]  mem_to_reg;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] branch_address;
    logic        alu_src1;
    logic        alu_src2;
    logic [5:0]  alu_fun;
    logic        sign;
    logic [4:0]  rd;
    logic [4:0]  rt;
    logic [4:0]  rs;
    logic [31:0] rt_data;
    logic [31:0] rs_data;
  } id_ex_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU for the EX stage.
// Compares return a single flag in bit 0.
module alu
  import cpu_pipe_pkg::*;
(
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic [5:0]  ALUFun,
  input  logic        Sign,
  output logic [31:0] result
);

  logic [4:0] sa;
  logic       lt;

  assign sa = in1[4:0];

  // less-than flag, signedness chosen per instruction
  always_comb begin
    lt = 1'b0;
    if (Sign)
      lt = $signed(in1) < $signed(in2);
    else
      lt = in1 < in2;
  end

  // function select; unknown codes give zero
  always_comb begin
    result = '0;
    case (ALUFun)
      ALU_ADD:   result = in1 + in2;
      ALU_SUB:   result = in1 - in2;
      ALU_AND:   result = in1 & in2;
      ALU_OR:    result = in1 | in2;
      ALU_XOR:   result = in1 ^ in2;
      ALU_NOR:   result = ~(in1 | in2);
      ALU_PASSA: result = in1;
      ALU_SLL:   result = in2 << sa;
      ALU_SRL:   result = in2 >> sa;
      ALU_SRA:   result = $unsigned($signed(in2) >>> sa);
      ALU_EQ:    result = {31'b0, in1 == in2};
      ALU_NEQ:   result = {31'b0, in1 != in2};
      ALU_LT:    result = {31'b0, lt};
      ALU_LEZ:   result = {31'b0, in1[31] | ~|in1};
      ALU_LTZ:   result = {31'b0, in1[31]};
      ALU_GTZ:   result = {31'b0, ~in1[31] & |in1};
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch resolve,
// one-slot squash after a taken branch, EX/MEM register.
module ex_stage
  import cpu_pipe_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic [ID_EX_W-1:0]   ID_EX,
  input  logic                 MEM_WB_RegWrite,
  input  logic [4:0]           MEM_WB_WriteReg,
  input  logic [31:0]          MEM_WB_RegWriteData,
  input  logic                 mem_stall,
  output logic                 PCSrcB,
  output logic [31:0]          branch_target,
  output logic                 flush,
  output logic [31:0]          EX_MEM_ALUOut,
  output logic [31:0]          EX_MEM_StoreData,
  output logic [4:0]           EX_MEM_WriteReg,
  output logic                 EX_MEM_MemRead,
  output logic                 EX_MEM_MemWrite,
  output logic                 EX_MEM_RegWrite,
  output logic [1:0]           EX_MEM_MemToReg,
  output logic [31:0]          EX_MEM_PC_Plus4
);

  id_ex_t      d;
  logic        squash;
  logic        ex_ok;
  logic        wb_ok;
  logic [31:0] fwd_ex;
  logic [31:0] fwd_a;
  logic [31:0] fwd_b;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [31:0] alu_out;
  logic [4:0]  wr_sel;
  logic        taken;

  assign d = id_ex_t'(ID_EX);

  // forward A/B: EX/MEM result beats MEM/WB, $0 never forwarded
  always_comb begin
    fwd_ex = EX_MEM_ALUOut;
    if (EX_MEM_MemToReg == M2R_PC4)
      fwd_ex = EX_MEM_PC_Plus4;
    ex_ok = EX_MEM_RegWrite && (EX_MEM_WriteReg != 5'd0);
    wb_ok = MEM_WB_RegWrite && (MEM_WB_WriteReg != 5'd0);
    fwd_a = d.rs_data;
    if (ex_ok && EX_MEM_WriteReg == d.rs)
      fwd_a = fwd_ex;
    else if (wb_ok && MEM_WB_WriteReg == d.rs)
      fwd_a = MEM_WB_RegWriteData;
    fwd_b = d.rt_data;
    if (ex_ok && EX_MEM_WriteReg == d.rt)
      fwd_b = fwd_ex;
    else if (wb_ok && MEM_WB_WriteReg == d.rt)
      fwd_b = MEM_WB_RegWriteData;
  end

  // ALU operand muxes
  always_comb begin
    alu_in1 = fwd_a;
    alu_in2 = fwd_b;
    if (d.alu_src1)
      alu_in1 = {27'b0, d.shamt};
    if (d.alu_src2)
      alu_in2 = d.imm32;
  end

  alu u_alu (
    .in1    (alu_in1),
    .in2    (alu_in2),
    .ALUFun (d.alu_fun),
    .Sign   (d.sign),
    .result (alu_out)
  );

  // destination register select
  always_comb begin
    wr_sel = d.rd;
    unique case (d.reg_dst)
      REGDST_RD: wr_sel = d.rd;
      REGDST_RT: wr_sel = d.rt;
      REGDST_RA: wr_sel = REG_RA;
      REGDST_K0: wr_sel = REG_K0;
      default:   wr_sel = d.rd;
    endcase
  end

  // branch resolve; a squashed slot or a stalled pipe never redirects
  always_comb begin
    taken = reset_b & d.branch & alu_out[0]
          & ~squash & ~mem_stall;
    PCSrcB        = taken;
    flush         = taken;
    branch_target = d.branch_address;
  end

  // EX/MEM register and squash flag; a squashed slot enters as a bubble
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      squash           <= 1'b0;
      EX_MEM_ALUOut    <= '0;
      EX_MEM_StoreData <= '0;
      EX_MEM_WriteReg  <= '0;
      EX_MEM_MemRead   <= 1'b0;
      EX_MEM_MemWrite  <= 1'b0;
      EX_MEM_RegWrite  <= 1'b0;
      EX_MEM_MemToReg  <= '0;
      EX_MEM_PC_Plus4  <= '0;
    end else if (!mem_stall) begin
      squash           <= taken;
      EX_MEM_ALUOut    <= d.lu_op ? d.lu_data : alu_out;
      EX_MEM_StoreData <= fwd_b;
      EX_MEM_WriteReg  <= wr_sel;
      EX_MEM_MemRead   <= d.mem_read & ~squash;
      EX_MEM_MemWrite  <= d.mem_write & ~squash;
      EX_MEM_RegWrite  <= d.reg_write & ~squash;
      EX_MEM_MemToReg  <= squash ? 2'b00 : d.mem_to_reg;
      EX_MEM_PC_Plus4  <= d.pc_plus4;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: ALU vector table, hand-written
// hazard/branch/stall/reset sequences, then random ops vs a model.
module tb_ex_stage;

  localparam logic [5:0] F_ADD = 6'b000000;
  localparam logic [5:0] F_SUB = 6'b000001;
  localparam logic [5:0] F_AND = 6'b011000;
  localparam logic [5:0] F_OR  = 6'b011110;
  localparam logic [5:0] F_XOR = 6'b010110;
  localparam logic [5:0] F_NOR = 6'b010001;
  localparam logic [5:0] F_PA  = 6'b011010;
  localparam logic [5:0] F_SLL = 6'b100000;
  localparam logic [5:0] F_SRL = 6'b100001;
  localparam logic [5:0] F_SRA = 6'b100011;
  localparam logic [5:0] F_EQ  = 6'b110011;
  localparam logic [5:0] F_NEQ = 6'b110001;
  localparam logic [5:0] F_LT  = 6'b110101;
  localparam logic [5:0] F_LEZ = 6'b111101;
  localparam logic [5:0] F_LTZ = 6'b111011;
  localparam logic [5:0] F_GTZ = 6'b111111;

  logic         clk = 1'b0;
  logic         reset_b;
  logic [229:0] ID_EX;
  logic         MEM_WB_RegWrite;
  logic [4:0]   MEM_WB_WriteReg;
  logic [31:0]  MEM_WB_RegWriteData;
  logic         mem_stall;
  logic         PCSrcB;
  logic [31:0]  branch_target;
  logic         flush;
  logic [31:0]  EX_MEM_ALUOut;
  logic [31:0]  EX_MEM_StoreData;
  logic [4:0]   EX_MEM_WriteReg;
  logic         EX_MEM_MemRead;
  logic         EX_MEM_MemWrite;
  logic         EX_MEM_RegWrite;
  logic [1:0]   EX_MEM_MemToReg;
  logic [31:0]  EX_MEM_PC_Plus4;

  ex_stage dut (
    .clk                 (clk),
    .reset_b             (reset_b),
    .ID_EX               (ID_EX),
    .MEM_WB_RegWrite     (MEM_WB_RegWrite),
    .MEM_WB_WriteReg     (MEM_WB_WriteReg),
    .MEM_WB_RegWriteData (MEM_WB_RegWriteData),
    .mem_stall           (mem_stall),
    .PCSrcB              (PCSrcB),
    .branch_target       (branch_target),
    .flush               (flush),
    .EX_MEM_ALUOut       (EX_MEM_ALUOut),
    .EX_MEM_StoreData    (EX_MEM_StoreData),
    .EX_MEM_WriteReg     (EX_MEM_WriteReg),
    .EX_MEM_MemRead      (EX_MEM_MemRead),
    .EX_MEM_MemWrite     (EX_MEM_MemWrite),
    .EX_MEM_RegWrite     (EX_MEM_RegWrite),
    .EX_MEM_MemToReg     (EX_MEM_MemToReg),
    .EX_MEM_PC_Plus4     (EX_MEM_PC_Plus4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rs_data, rt_data, baddr;
    logic [31:0] ludata, pc4, imm;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  fun;
    logic [1:0]  m2r, regdst;
    logic        src1, src2, sign, mr, mw;
    logic        rw, luop, br;
  } op_t;

  typedef struct {
    logic [31:0] alu, store, pc4;
    logic [4:0]  wr;
    logic [1:0]  m2r;
    logic        mr, mw, rw;
  } em_t;

  typedef struct {
    op_t         o;
    logic [31:0] exp_out;
    logic [4:0]  exp_wr;
  } tv_t;

  em_t  em, em_nx;
  logic sq, sq_nx;
  logic e_taken;
  logic [31:0] e_target;
  logic seen_pcsrc, seen_flush;
  tv_t  tvs[$];

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t",
               n, act, exp, $time);
    end
  endtask

  function automatic op_t nop();
    op_t o;
    o.rs_data = 0; o.rt_data = 0; o.baddr = 0;
    o.ludata = 0; o.pc4 = 0; o.imm = 0;
    o.rs = 0; o.rt = 0; o.rd = 0; o.shamt = 0;
    o.fun = 0; o.m2r = 0; o.regdst = 0;
    o.src1 = 0; o.src2 = 0; o.sign = 0;
    o.mr = 0; o.mw = 0; o.rw = 0;
    o.luop = 0; o.br = 0;
    return o;
  endfunction

  function automatic em_t em_zero();
    em_t e;
    e.alu = 0; e.store = 0; e.pc4 = 0; e.wr = 0;
    e.m2r = 0; e.mr = 0; e.mw = 0; e.rw = 0;
    return e;
  endfunction

  function automatic logic [229:0] pack_op(op_t o);
    logic [229:0] v;
    v = '0;
    v[31:0]    = o.rs_data;
    v[63:32]   = o.rt_data;
    v[68:64]   = o.rs;
    v[73:69]   = o.rt;
    v[78:74]   = o.rd;
    v[79]      = o.sign;
    v[85:80]   = o.fun;
    v[86]      = o.src2;
    v[87]      = o.src1;
    v[119:88]  = o.baddr;
    v[120]     = o.mw;
    v[121]     = o.mr;
    v[122]     = o.rw;
    v[124:123] = o.m2r;
    v[156:125] = o.ludata;
    v[157]     = o.luop;
    v[189:158] = o.pc4;
    v[194:190] = o.shamt;
    v[226:195] = o.imm;
    v[227]     = o.br;
    v[229:228] = o.regdst;
    return v;
  endfunction

  function automatic logic [31:0] ref_alu(
    logic [5:0] f, logic [31:0] a,
    logic [31:0] b, logic s);
    logic [4:0]  n;
    logic [31:0] fill;
    n = a[4:0];
    fill = b[31] ? ~(32'hFFFF_FFFF >> n) : 32'h0;
    case (f)
      F_ADD: return a + b;
      F_SUB: return a + ~b + 32'd1;
      F_AND: return a & b;
      F_OR:  return a | b;
      F_XOR: return a ^ b;
      F_NOR: return ~a & ~b;
      F_PA:  return a;
      F_SLL: return b << n;
      F_SRL: return b >> n;
      F_SRA: return (b >> n) | fill;
      F_EQ:  return {31'b0, a == b};
      F_NEQ: return {31'b0, a != b};
      F_LT:  return s ? {31'b0, (a ^ 32'h8000_0000)
                                 < (b ^ 32'h8000_0000)}
                      : {31'b0, a < b};
      F_LEZ: return {31'b0, a[31] || a == 0};
      F_LTZ: return {31'b0, a[31]};
      F_GTZ: return {31'b0, !a[31] && a != 0};
      default: return 32'h0;
    endcase
  endfunction

  // value the pipeline holds for register r right now
  function automatic logic [31:0] reg_val(
    logic [4:0] r, logic [31:0] fileval);
    if (r != 0 && em.rw && em.wr == r)
      return (em.m2r == 2'b10) ? em.pc4 : em.alu;
    if (r != 0 && MEM_WB_RegWrite && MEM_WB_WriteReg == r)
      return MEM_WB_RegWriteData;
    return fileval;
  endfunction

  task automatic model_eval(input op_t o);
    logic [31:0] a, b, i1, i2, r;
    logic [4:0]  w;
    a  = reg_val(o.rs, o.rs_data);
    b  = reg_val(o.rt, o.rt_data);
    i1 = o.src1 ? {27'b0, o.shamt} : a;
    i2 = o.src2 ? o.imm : b;
    r  = ref_alu(o.fun, i1, i2, o.sign);
    e_taken  = reset_b && o.br && r[0] && !sq && !mem_stall;
    e_target = o.baddr;
    case (o.regdst)
      2'd0: w = o.rd;
      2'd1: w = o.rt;
      2'd2: w = 5'd31;
      default: w = 5'd26;
    endcase
    if (!reset_b) begin
      em_nx = em_zero();
      sq_nx = 1'b0;
    end else if (mem_stall) begin
      em_nx = em;
      sq_nx = sq;
    end else begin
      em_nx.alu   = o.luop ? o.ludata : r;
      em_nx.store = b;
      em_nx.wr    = w;
      em_nx.pc4   = o.pc4;
      em_nx.mr    = o.mr && !sq;
      em_nx.mw    = o.mw && !sq;
      em_nx.rw    = o.rw && !sq;
      em_nx.m2r   = sq ? 2'b00 : o.m2r;
      sq_nx       = e_taken;
    end
  endtask

  task automatic chk_regs();
    chk("alu_out",   EX_MEM_ALUOut,    em.alu);
    chk("store",     EX_MEM_StoreData, em.store);
    chk("write_reg", {27'b0, EX_MEM_WriteReg}, {27'b0, em.wr});
    chk("mem_read",  {31'b0, EX_MEM_MemRead},  {31'b0, em.mr});
    chk("mem_write", {31'b0, EX_MEM_MemWrite}, {31'b0, em.mw});
    chk("reg_write", {31'b0, EX_MEM_RegWrite}, {31'b0, em.rw});
    chk("mem2reg",   {30'b0, EX_MEM_MemToReg}, {30'b0, em.m2r});
    chk("pc4",       EX_MEM_PC_Plus4,  em.pc4);
  endtask

  // one clock: drive, check combinational outputs, edge, check regs
  task automatic run(input op_t o);
    ID_EX = pack_op(o);
    #1;
    model_eval(o);
    seen_pcsrc = PCSrcB;
    seen_flush = flush;
    chk("pcsrcb", {31'b0, PCSrcB}, {31'b0, e_taken});
    chk("flush",  {31'b0, flush},  {31'b0, e_taken});
    chk("target", branch_target, e_target);
    @(posedge clk);
    em = em_nx;
    sq = sq_nx;
    #1;
    chk_regs();
    @(negedge clk);
  endtask

  function automatic op_t alu_op(logic [5:0] f,
                                 logic [31:0] a,
                                 logic [31:0] b,
                                 logic [4:0] rd);
    op_t o;
    o = nop();
    o.fun = f; o.rs_data = a; o.rt_data = b;
    o.rd = rd; o.rw = 1'b1;
    return o;
  endfunction

  task automatic add_tv(input op_t o,
                        input logic [31:0] e,
                        input logic [4:0] w);
    tv_t t;
    t.o = o; t.exp_out = e; t.exp_wr = w;
    tvs.push_back(t);
  endtask

  function automatic op_t beq(logic [31:0] ba, logic rw);
    op_t o;
    o = alu_op(F_EQ, 32'd4, 32'd4, 5'd9);
    o.br = 1'b1; o.baddr = ba; o.rw = rw;
    return o;
  endfunction

  function automatic logic [5:0] pick_fun();
    logic [5:0] fs [16];
    fs = '{F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR,
           F_PA, F_SLL, F_SRL, F_SRA, F_EQ, F_NEQ,
           F_LT, F_LEZ, F_LTZ, F_GTZ};
    if ($urandom_range(0, 19) == 0)
      return 6'($urandom);
    return fs[$urandom_range(0, 15)];
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.rs_data = $urandom; o.rt_data = $urandom;
    if ($urandom_range(0, 3) == 0) o.rt_data = o.rs_data;
    o.baddr = $urandom; o.ludata = $urandom;
    o.pc4 = $urandom; o.imm = $urandom;
    o.rs = 5'($urandom_range(0, 7));
    o.rt = 5'($urandom_range(0, 7));
    o.rd = 5'($urandom_range(0, 7));
    o.shamt = 5'($urandom);
    o.fun = pick_fun();
    o.m2r = 2'($urandom); o.regdst = 2'($urandom);
    o.src1 = ($urandom_range(0, 9) == 0);
    o.src2 = ($urandom_range(0, 6) == 0);
    o.sign = 1'($urandom);
    o.mr = 1'($urandom); o.mw = 1'($urandom);
    o.rw = ($urandom_range(0, 9) < 6);
    o.luop = ($urandom_range(0, 9) == 0);
    o.br = ($urandom_range(0, 9) < 3);
    return o;
  endfunction

  initial begin
    op_t o;
    em = em_zero();
    sq = 1'b0;
    reset_b = 1'b0;
    mem_stall = 1'b1;
    MEM_WB_RegWrite = 1'b0;
    MEM_WB_WriteReg = 5'd0;
    MEM_WB_RegWriteData = 32'd0;

    // reset with a taken-looking branch and a stall present
    run(beq(32'h100, 1'b1));
    chk("rst_pcsrc", {31'b0, seen_pcsrc}, 32'd0);
    mem_stall = 1'b0;
    run(beq(32'h100, 1'b1));
    chk("rst_flush", {31'b0, seen_flush}, 32'd0);
    chk("rst_rw", {31'b0, EX_MEM_RegWrite}, 32'd0);
    chk("rst_alu", EX_MEM_ALUOut, 32'd0);
    reset_b = 1'b1;

    // ALU vector table; $0 operands so nothing forwards,
    // and MEM/WB writing $0 must be ignored
    add_tv(alu_op(F_ADD, 5, 7, 3), 32'd12, 5'd3);
    add_tv(alu_op(F_SUB, 5, 7, 4), 32'hFFFF_FFFE, 5'd4);
    add_tv(alu_op(F_ADD, 32'hFFFF_FFFF, 1, 5), 0, 5'd5);
    add_tv(alu_op(F_AND, 32'hF0F0, 32'hFF00, 6), 32'hF000, 5'd6);
    add_tv(alu_op(F_OR,  32'hF0F0, 32'hFF00, 7), 32'hFFF0, 5'd7);
    add_tv(alu_op(F_XOR, 32'hF0F0, 32'hFF00, 8), 32'h0FF0, 5'd8);
    add_tv(alu_op(F_NOR, 0, 0, 9), 32'hFFFF_FFFF, 5'd9);
    add_tv(alu_op(F_PA, 32'h1234, 7, 10), 32'h1234, 5'd10);
    o = alu_op(F_SLL, 0, 1, 11); o.src1 = 1; o.shamt = 4;
    add_tv(o, 32'h10, 5'd11);
    o = alu_op(F_SRL, 0, 32'h8000_0000, 12);
    o.src1 = 1; o.shamt = 4;
    add_tv(o, 32'h0800_0000, 5'd12);
    o = alu_op(F_SRA, 0, 32'h8000_0000, 13);
    o.src1 = 1; o.shamt = 4;
    add_tv(o, 32'hF800_0000, 5'd13);
    o = alu_op(F_LT, 32'hFFFF_FFFF, 1, 14); o.sign = 1;
    add_tv(o, 32'd1, 5'd14);
    add_tv(alu_op(F_LT, 32'hFFFF_FFFF, 1, 15), 32'd0, 5'd15);
    add_tv(alu_op(F_EQ, 4, 4, 16), 32'd1, 5'd16);
    add_tv(alu_op(F_NEQ, 4, 4, 17), 32'd0, 5'd17);
    add_tv(alu_op(F_LEZ, 0, 0, 18), 32'd1, 5'd18);
    add_tv(alu_op(F_LTZ, 32'h8000_0000, 0, 19), 32'd1, 5'd19);
    add_tv(alu_op(F_GTZ, 0, 0, 20), 32'd0, 5'd20);
    add_tv(alu_op(6'b111000, 3, 3, 21), 32'd0, 5'd21);
    o = alu_op(F_ADD, 1, 1, 22);
    o.luop = 1; o.ludata = 32'hABCD_0000;
    add_tv(o, 32'hABCD_0000, 5'd22);
    o = alu_op(F_ADD, 5, 9, 23); o.src2 = 1; o.imm = 100;
    add_tv(o, 32'd105, 5'd23);
    o = alu_op(F_ADD, 1, 2, 23); o.regdst = 2'b01;
    add_tv(o, 32'd3, 5'd0);
    o = alu_op(F_ADD, 1, 2, 23); o.regdst = 2'b10;
    add_tv(o, 32'd3, 5'd31);
    o = alu_op(F_ADD, 1, 2, 23); o.regdst = 2'b11;
    add_tv(o, 32'd3, 5'd26);

    MEM_WB_RegWrite = 1'b1;
    MEM_WB_WriteReg = 5'd0;
    MEM_WB_RegWriteData = 32'hDEAD_BEEF;
    for (int i = 0; i < tvs.size(); i++) begin
      run(tvs[i].o);
      chk("tbl_out", EX_MEM_ALUOut, tvs[i].exp_out);
      chk("tbl_wr", {27'b0, EX_MEM_WriteReg},
          {27'b0, tvs[i].exp_wr});
      chk("tbl_rw", {31'b0, EX_MEM_RegWrite}, 32'd1);
      chk("tbl_st", EX_MEM_StoreData, tvs[i].o.rt_data);
    end

    // back-to-back forwarding, EX/MEM beats MEM/WB
    MEM_WB_RegWrite = 1'b0;
    run(alu_op(F_ADD, 5, 7, 3));
    o = alu_op(F_ADD, 1, 0, 4); o.rs = 1; o.rt = 3;
    MEM_WB_RegWrite = 1'b1;
    MEM_WB_WriteReg = 5'd3;
    MEM_WB_RegWriteData = 32'd9;
    run(o);
    chk("fwd_ex_b", EX_MEM_StoreData, 32'd12);
    chk("fwd_ex_sum", EX_MEM_ALUOut, 32'd13);
    o = alu_op(F_ADD, 0, 0, 10); o.rs = 3;
    run(o);
    chk("fwd_wb_a", EX_MEM_ALUOut, 32'd9);
    MEM_WB_RegWrite = 1'b0;
    o = alu_op(F_PA, 0, 0, 0);
    o.regdst = 2'b10; o.m2r = 2'b10; o.pc4 = 32'h400;
    run(o);
    o = alu_op(F_ADD, 0, 0, 11); o.rs = 31;
    run(o);
    chk("fwd_pc4", EX_MEM_ALUOut, 32'h400);

    // taken branch, then squashed slot
    run(beq(32'h100, 1'b0));
    chk("br_pcsrc", {31'b0, seen_pcsrc}, 32'd1);
    chk("br_flush", {31'b0, seen_flush}, 32'd1);
    chk("br_rw", {31'b0, EX_MEM_RegWrite}, 32'd0);
    run(alu_op(F_ADD, 1, 2, 5));
    chk("sq_pcsrc", {31'b0, seen_pcsrc}, 32'd0);
    chk("sq_rw", {31'b0, EX_MEM_RegWrite}, 32'd0);
    run(alu_op(F_ADD, 1, 2, 6));
    chk("post_sq_rw", {31'b0, EX_MEM_RegWrite}, 32'd1);
    run(beq(32'h140, 1'b0));
    run(beq(32'h180, 1'b1));
    chk("sq_br_pcsrc", {31'b0, seen_pcsrc}, 32'd0);
    chk("sq_br_rw", {31'b0, EX_MEM_RegWrite}, 32'd0);

    // stall holding a taken branch in EX
    run(alu_op(F_ADD, 1, 2, 5));
    mem_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      run(beq(32'h200, 1'b0));
      chk("stl_flush", {31'b0, seen_flush}, 32'd0);
      chk("stl_hold", EX_MEM_ALUOut, 32'd3);
      chk("stl_rw", {31'b0, EX_MEM_RegWrite}, 32'd1);
    end
    mem_stall = 1'b0;
    run(beq(32'h200, 1'b0));
    chk("stl_rel_flush", {31'b0, seen_flush}, 32'd1);
    run(alu_op(F_ADD, 1, 2, 6));
    chk("stl_once", {31'b0, seen_flush}, 32'd0);
    chk("stl_sq_rw", {31'b0, EX_MEM_RegWrite}, 32'd0);

    // reset beats pending squash and stall
    run(alu_op(F_ADD, 1, 2, 7));
    run(beq(32'h300, 1'b1));
    reset_b = 1'b0;
    mem_stall = 1'b1;
    run(beq(32'h300, 1'b1));
    chk("rs2_pcsrc", {31'b0, seen_pcsrc}, 32'd0);
    chk("rs2_rw", {31'b0, EX_MEM_RegWrite}, 32'd0);
    chk("rs2_alu", EX_MEM_ALUOut, 32'd0);
    chk("rs2_wr", {27'b0, EX_MEM_WriteReg}, 32'd0);
    reset_b = 1'b1;
    mem_stall = 1'b0;
    run(alu_op(F_ADD, 10, 20, 8));
    chk("rs2_first_rw", {31'b0, EX_MEM_RegWrite}, 32'd1);
    chk("rs2_first_alu", EX_MEM_ALUOut, 32'd30);

    // random traffic against the model
    for (int i = 0; i < 800; i++) begin
      reset_b = ($urandom_range(0, 39) != 0);
      mem_stall = ($urandom_range(0, 4) == 0);
      MEM_WB_RegWrite = 1'($urandom);
      MEM_WB_WriteReg = 5'($urandom_range(0, 7));
      MEM_WB_RegWriteData = $urandom;
      run(rand_op());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have ports: clk  in  1  pipeline clock (rising edge); reset_b  in  1  synchronous, active-low reset.
REQ-002 SHALL have ports: ID_EX  in  230  decoded bundle, layout per REQ-022; MEM_WB_RegWrite  in  1; MEM_WB_WriteReg  in  5; MEM_WB_RegWriteData  in  32; mem_stall  in  1  MEM-stage hold request.
REQ-003 SHALL have ports: PCSrcB  out  1  taken branch; branch_target  out  32; flush  out  1  squash IF/ID and ID_EX next edge.
REQ-004 SHALL have ports: EX_MEM_ALUOut  out  32; EX_MEM_StoreData  out  32; EX_MEM_WriteReg  out  5; EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_RegWrite  out  1 each; EX_MEM_MemToReg  out  2; EX_MEM_PC_Plus4  out  32.

Function
REQ-005 SHALL register all EX_MEM_* outputs on rising clk: one-cycle latency from ID_EX to EX_MEM.
REQ-006 SHALL forward operand A (Rs) and B (Rt), priority: EX_MEM (EX_MEM_RegWrite, WriteReg!=0, match) > MEM_WB (RegWrite, WriteReg!=0, match) > ID_EX register data.
REQ-007 EX_MEM forward value SHALL be EX_MEM_PC_Plus4 when EX_MEM_MemToReg==2'b10, else EX_MEM_ALUOut; register 0 SHALL never be forwarded.
REQ-008 ALU input 1 SHALL be {27'b0,Shamt} when ALUSrc1=1, else forwarded A; input 2 SHALL be Imm32 when ALUSrc2=1, else forwarded B.
REQ-009 ALU SHALL implement ALUFun codes in package: ADD 000000, SUB 000001, AND 011000, OR 011110, XOR 010110, NOR 010001, PASSA 011010, SLL 100000, SRL 100001, SRA 100011, EQ 110011, NEQ 110001, LT 110101, LEZ 111101, LTZ 111011, GTZ 111111; shifts by in1[4:0] of in2; compares return {31'b0,flag}; LT signed when Sign=1, unsigned otherwise; add/sub wrap modulo 2^32; undefined codes yield 0.
REQ-010 When LUOp=1, EX_MEM_ALUOut SHALL take LUData field instead of ALU result.
REQ-011 EX_MEM_WriteReg SHALL be Rd (RegDst 00), Rt (01), 31 (10), 26 (11).
REQ-012 EX_MEM_StoreData SHALL be forwarded B.
REQ-013 PCSrcB and flush SHALL assert combinationally when Branch=1, ALU result[0]=1, squash=0, mem_stall=0; branch_target = branch_address field.
REQ-014 Internal squash flag SHALL set on the edge where flush=1 and clear on next non-stalled edge; while squash=1 the incoming ID_EX entry SHALL be latched as bubble (all EX_MEM control bits 0) and SHALL NOT branch.
REQ-015 While mem_stall=1: EX_MEM register and squash SHALL hold; PCSrcB, flush SHALL be 0; branch re-evaluated after stall drops.
REQ-016 Bubble ID_EX (all zero) SHALL produce EX_MEM with RegWrite=MemRead=MemWrite=0.
REQ-017 Taken branch itself SHALL pass to EX_MEM with its own control (normally RegWrite=0).

Reset
REQ-018 reset_b=0 at rising clk SHALL clear all EX_MEM_* registers to 0 and squash to 0.
REQ-019 During reset PCSrcB and flush SHALL be 0 regardless of ID_EX.
REQ-020 Reset SHALL override mem_stall and a pending squash.
REQ-021 First edge after reset release SHALL latch ID_EX normally.

Structure
REQ-022 Shared package cpu_pipe_pkg SHALL hold ALUFun constants, RegDst/MemToReg encodings, ID_EX width (230) and field offsets: RsData[31:0], RtData[63:32], Rs[68:64], Rt[73:69], Rd[78:74], {ALUSrc1,ALUSrc2,ALUFun,Sign}[87:79], branch_address[119:88], {MemRead,MemWrite}[121:120], {MemToReg,RegWrite}[124:122], {LUOp,LUData}[157:125], PC_Plus4[189:158], Shamt[194:190], Imm32[226:195], Branch[227], RegDst[229:228].
REQ-023 Combinational ALU SHALL be sub-module alu (in1, in2, ALUFun, Sign -> result); forwarding, branch, squash and EX_MEM register in ex_stage.

Verification
REQ-024 ADD $3=$1+$2, RsData=5, RtData=7 -> EX_MEM_ALUOut=12, WriteReg=3, RegWrite=1 one edge later.
REQ-025 Back-to-back: EX_MEM writes $3=12, next ADD reads $3 with stale RtData=0 -> B=12; same with MEM_WB $3=9 also matching -> EX_MEM value 12 wins.
REQ-026 BEQ (ALUFun EQ) A=B=4, branch_address=0x100 -> PCSrcB=flush=1, branch_target=0x100; next ID_EX (ADD to $5) -> EX_MEM_RegWrite=0.
REQ-027 LT Sign=1: A=0xFFFFFFFF, B=1 -> 1; Sign=0 -> 0; SRA shamt 4 on 0x80000000 -> 0xF8000000.
REQ-028 mem_stall=1 for 2 cycles with taken branch in EX -> EX_MEM held, flush=0; stall drops -> flush=1 once.
REQ-029 reset_b=0 with squash set and RegWrite=1 in EX_MEM -> all outputs 0, next entry not squashed.
